// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: direction codes, PS/2
// scan-code constants, receiver FSM states and the make-code lookup.
package snake_pkg;

  // Direction codes driven on kb and consumed by the game block
  localparam logic [3:0] DIR_UP    = 4'b0000;
  localparam logic [3:0] DIR_DOWN  = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0011;
  localparam logic [3:0] DIR_STOP  = 4'b1111;

  // Prefix and special scan codes (set 2)
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Frame receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Result of looking up a final scan code
  typedef struct packed {
    logic       valid;
    logic [3:0] dir;
  } dir_req_t;

  // Arrow keys need the E0 prefix; WASD keys are plain codes.
  function automatic dir_req_t map_code(input logic ext, input logic [7:0] code);
    dir_req_t req;
    req.valid = 1'b1;
    req.dir   = DIR_STOP;
    if (ext) begin
      case (code)
        8'h75:   req.dir = DIR_UP;
        8'h72:   req.dir = DIR_DOWN;
        8'h6B:   req.dir = DIR_LEFT;
        8'h74:   req.dir = DIR_RIGHT;
        default: req.valid = 1'b0;
      endcase
    end else begin
      case (code)
        8'h1D:   req.dir = DIR_UP;
        8'h1B:   req.dir = DIR_DOWN;
        8'h1C:   req.dir = DIR_LEFT;
        8'h23:   req.dir = DIR_RIGHT;
        default: req.valid = 1'b0;
      endcase
    end
    return req;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the bus lines, detects falling edges of
// the PS/2 clock, assembles 11-bit frames and flags malformed or stalled ones.
module ps2_rx
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_rdy,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  logic [1:0]  r_clk_sync;
  logic [1:0]  r_dat_sync;
  logic        r_clk_prev;
  logic        r_fall;
  logic        r_bit;
  rx_state_t   r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic [15:0] r_to_cnt;
  logic        r_byte_rdy;
  logic [7:0]  r_byte_data;
  logic        r_frame_err;
  logic        w_timeout;

  // Two-flop synchronisers plus a registered falling-edge strobe on ps2_clk
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchronisers reset to 1 so an idle bus does not look like a falling edge after reset.
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
      r_fall     <= 1'b0;
      r_bit      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take its neighbour's pre-edge value, forming a real shift chain.
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      r_clk_prev <= r_clk_sync[1];
      r_fall     <= r_clk_prev & ~r_clk_sync[1];
      r_bit      <= r_dat_sync[1];
    end
  end

  assign w_timeout = (r_state != RX_IDLE) && (r_to_cnt >= TO_LIM);

  // Inter-edge watchdog: clears on every edge, counts (saturating) mid-frame
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_timeout || r_fall || (r_state == RX_IDLE)) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != 16'hFFFF) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // Frame FSM with registered byte-ready and error pulses; timeout beats an edge
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RX_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_byte_rdy  <= 1'b0;
      r_byte_data <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_timeout) begin
        r_state     <= RX_IDLE;
        r_bit_cnt   <= '0;
        r_shift     <= '0;
        r_frame_err <= 1'b1;
      end else if (r_fall) begin
        case (r_state)
          RX_IDLE: begin
            if (!r_bit) begin
              r_state   <= RX_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          RX_DATA: begin
            r_shift <= {r_bit, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= RX_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          RX_PARITY: begin
            r_parity <= r_bit;
            r_state  <= RX_STOP;
          end
          RX_STOP: begin
            if (r_bit && (^{r_shift, r_parity})) begin
              r_byte_rdy  <= 1'b1;
              r_byte_data <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= RX_IDLE;
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign o_byte_rdy  = r_byte_rdy;
  assign o_byte_data = r_byte_data;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_dir_decoder.sv
// Turns PS/2 keyboard make-codes into the snake direction code and an Enter
// start pulse. Tracks the E0/F0 prefixes and filters reversals and repeats.
module ps2_dir_decoder
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYC   = 50000,
  parameter int ALLOW_REVERSE = 0
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] kb,
  output logic       dir_valid,
  output logic       start,
  output logic       frame_err
);

  logic       w_byte_rdy;
  logic [7:0] w_byte_data;
  logic       w_frame_err;
  dir_req_t   w_req;
  logic       w_opposite;
  logic       w_accept;

  logic       r_ext;
  logic       r_brk;
  logic [3:0] r_kb;
  logic       r_dir_valid;
  logic       r_start;

  ps2_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_byte_rdy  (w_byte_rdy),
    .o_byte_data (w_byte_data),
    .o_frame_err (w_frame_err)
  );

  // Look up the received code and decide whether it changes the direction
  always_comb begin
    w_req      = map_code(r_ext, w_byte_data);
    w_opposite = (r_kb != DIR_STOP) && (w_req.dir == (r_kb ^ 4'b0001));
    w_accept   = w_req.valid && (w_req.dir != r_kb) &&
                 ((ALLOW_REVERSE != 0) || !w_opposite);
  end

  // Prefix tracking, direction latch and output pulses
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_kb        <= DIR_STOP;
      r_dir_valid <= 1'b0;
      r_start     <= 1'b0;
    end else begin
      r_dir_valid <= 1'b0;
      r_start     <= 1'b0;
      if (w_byte_rdy) begin
        if (w_byte_data == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte_data == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (!r_brk) begin
            if (w_accept) begin
              r_kb        <= w_req.dir;
              r_dir_valid <= 1'b1;
            end
            if (!r_ext && (w_byte_data == SC_ENTER)) begin
              r_start <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign kb        = r_kb;
  assign dir_valid = r_dir_valid;
  assign start     = r_start;
  assign frame_err = w_frame_err;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Scoreboard bench for ps2_dir_decoder: a key-event model predicts output
// pulses, a monitor matches every pulse against the expectation queue.
module tb_ps2_dir_decoder;

  localparam int TO   = 2000;  // shortened inter-edge timeout keeps the run brief
  localparam int HALF = 10;    // PS/2 clock half period in clk_50 cycles
  localparam int GAP  = 8;

  typedef enum int {EV_DIR, EV_START, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [3:0] kb;
    int         min_cyc;
    int         max_cyc;
  } exp_t;

  logic       clk_50   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] kb;
  logic       dir_valid;
  logic       start;
  logic       frame_err;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  exp_t       pend;
  bit         pend_on = 0;
  logic [3:0] model_kb = 4'hF;

  ps2_dir_decoder #(
    .TIMEOUT_CYC   (TO),
    .ALLOW_REVERSE (0)
  ) dut (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .kb        (kb),
    .dir_valid (dir_valid),
    .start     (start),
    .frame_err (frame_err)
  );

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic observe(input ev_kind_t k);
    exp_t e;
    check("pulse_expected", (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pulse_kind", k, e.kind);
      if (k == EV_DIR) check("kb_on_dir_valid", kb, e.kb);
      checks++;
      if (cyc < e.min_cyc || cyc > e.max_cyc) begin
        errors++;
        $display("FAIL pulse_latency: got cycle %0d expected %0d..%0d", cyc, e.min_cyc, e.max_cyc);
      end
    end
  endtask

  always @(negedge clk_50) begin
    if (rst_n) begin
      if (dir_valid) observe(EV_DIR);
      if (start)     observe(EV_START);
      if (frame_err) observe(EV_ERR);
    end
  end

  // ---------------- PS/2 driver ----------------
  task automatic expect_ev(input ev_kind_t k, input logic [3:0] v, input int lo, input int hi);
    pend = '{kind: k, kb: v, min_cyc: lo, max_cyc: hi};
    pend_on = 1;
  endtask

  // One PS/2 bit; the pending expectation is anchored to this bit's falling edge if last=1
  task automatic ps2_bit(input logic b, input bit last);
    @(negedge clk_50);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk_50);
    ps2_clk = 1'b0;
    if (last && pend_on) begin
      pend.min_cyc += cyc;
      pend.max_cyc += cyc;
      exp_q.push_back(pend);
      pend_on = 0;
    end
    repeat (HALF) @(negedge clk_50);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk_50);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    logic par;
    par = ~^b;
    if (bad_par) par = ~par;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit(par, 0);
    ps2_bit(bad_stop ? 1'b0 : 1'b1, 1);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk_50);
  endtask

  // ---------------- key-event model ----------------
  function automatic logic [7:0] dir_code(input int d, input bit arrow);
    logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] wasd   [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    return arrow ? arrows[d] : wasd[d];
  endfunction

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      4'd0:    return 4'd1;
      4'd1:    return 4'd0;
      4'd2:    return 4'd3;
      4'd3:    return 4'd2;
      default: return 4'hE;
    endcase
  endfunction

  // Press a direction key: taken unless it repeats or reverses the current heading
  task automatic key_dir(input int d, input bit arrow);
    bit take;
    take = (4'(d) != model_kb) && (model_kb == 4'hF || 4'(d) != opposite(model_kb));
    if (arrow) send_frame(8'hE0);
    if (take) begin
      expect_ev(EV_DIR, 4'(d), 5, 5);
      model_kb = 4'(d);
    end
    send_frame(dir_code(d, arrow));
  endtask

  // Release a key: never changes anything
  task automatic key_break(input logic [7:0] code, input bit ext);
    if (ext) send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(code);
  endtask

  task automatic key_enter();
    expect_ev(EV_START, model_kb, 5, 5);
    send_frame(8'h5A);
  endtask

  // Keys with no meaning to the game, including keypad Enter (E0 5A)
  task automatic key_other();
    logic [7:0] plain [6] = '{8'h15, 8'h24, 8'h29, 8'h76, 8'h0E, 8'h45};
    logic [7:0] ext   [3] = '{8'h5A, 8'h1F, 8'h70};
    if ($urandom_range(1)) begin
      send_frame(8'hE0);
      send_frame(ext[$urandom_range(2)]);
    end else begin
      send_frame(plain[$urandom_range(5)]);
    end
  endtask

  task automatic bad_frame(input int kind);
    expect_ev(EV_ERR, model_kb, 4, 4);
    case (kind)
      0: send_frame(8'($urandom), 1, 0);
      1: send_frame(8'($urandom), 0, 1);
      default: begin
        ps2_bit(1'b1, 1);
        repeat (GAP) @(negedge clk_50);
      end
    endcase
  endtask

  task automatic kb_check(input string name);
    @(negedge clk_50);
    check(name, kb, model_kb);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (5) @(negedge clk_50);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_50);
    check("reset_kb", kb, 4'hF);
    check("reset_dir_valid", dir_valid, 0);
    check("reset_start", start, 0);
    check("reset_frame_err", frame_err, 0);

    key_dir(0, 1);                       // E0 75 -> up
    kb_check("arrow_up");
    key_break(8'h75, 1);                 // E0 F0 75 -> no change
    kb_check("arrow_break");
    key_dir(3, 0);                       // D -> right
    kb_check("wasd_right");
    key_dir(2, 0);                       // A -> reverse, dropped
    kb_check("reverse_dropped");
    key_dir(0, 0);                       // W -> up
    kb_check("wasd_up");
    key_dir(0, 0);                       // repeat W -> silent
    kb_check("repeat_silent");
    key_dir(2, 1);                       // E0 6B -> left
    kb_check("arrow_left");

    expect_ev(EV_ERR, model_kb, 4, 4);   // 1B with even parity
    send_frame(8'h1B, 1, 0);
    kb_check("bad_parity_kb");
    key_dir(1, 0);                       // valid 1B -> down
    kb_check("after_bad_parity");

    // Stall after 4 data bits
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0);
    expect_ev(EV_ERR, model_kb, TO + 3, TO + 7);
    ps2_bit(1'b0, 1);
    ps2_data = 1'b1;
    repeat (TO + 50) @(negedge clk_50);
    check("timeout_drained", exp_q.size(), 0);
    key_enter();
    kb_check("after_timeout");

    // Break prefix pending, then reset during bit 5 of a new frame
    send_frame(8'hF0);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1, 0);
    @(negedge clk_50);
    ps2_data = 1'b0;
    repeat (HALF / 2) @(negedge clk_50);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk_50);
    rst_n = 1'b0;
    #1;
    check("midreset_kb", kb, 4'hF);
    check("midreset_dir_valid", dir_valid, 0);
    check("midreset_start", start, 0);
    check("midreset_frame_err", frame_err, 0);
    model_kb = 4'hF;
    exp_q.delete();
    pend_on = 0;
    repeat (6) @(negedge clk_50);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (6) @(negedge clk_50);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_50);
    key_dir(2, 0);                       // A from stopped, break flag must be gone
    kb_check("after_midreset");

    // Random key traffic
    for (int n = 0; n < 70; n++) begin
      int r;
      r = $urandom_range(99);
      if (r < 55)      key_dir($urandom_range(3), 1'($urandom_range(1)));
      else if (r < 66) begin
        if ($urandom_range(1)) key_break(dir_code($urandom_range(3), 1), 1);
        else                   key_break(dir_code($urandom_range(3), 0), 0);
      end
      else if (r < 73) key_enter();
      else if (r < 82) key_other();
      else             bad_frame($urandom_range(2));
      kb_check("random_kb");
    end

    repeat (20) @(negedge clk_50);
    check("queue_empty", exp_q.size(), 0);
    check("final_kb", kb, model_kb);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (300000) @(posedge clk_50);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
